microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Control-unit next-state engine that drives the 6-bit index into the 64 x 55 microstore ROM.
- Each cycle it takes the next-state fields of the current microword, plus datapath status and the instruction encoder address, and registers the next microstore index.
- Adds conditional branching, encoder dispatch, memory-wait stalls and a small microsubroutine return stack, so microcode can share common sequences.

Parameters:
ADDR_W, 6, microstore index width (64 entries)
RESET_ADDR, 0, index loaded on reset; also the fetch/fallback address
STACK_DEPTH, 2, return-stack entries (1..4)
WDOG_CYCLES, 16, WAIT timeout in cycles (used only with the optional feature)
TRAP_ADDR, 63, index taken on watchdog timeout (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
halt  in  1  freeze: index, stack and flags hold
mop  in  3  microword next-state op (encodings below)
cr_addr  in  ADDR_W  microword target-address field
cond_sel  in  3  selects one bit of cond_in
cond_inv  in  1  inverts the selected condition
cond_in  in  8  status bits: [0] MOC, [1] condition-tester result, [2..7] datapath flags
dec_addr  in  ADDR_W  instruction encoder dispatch address
index  out  ADDR_W  registered microstore index
stack_ovf  out  1  sticky: CALL issued with the stack full
stack_unf  out  1  sticky: RET issued with the stack empty
wdog_to  out  1  sticky watchdog timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (async, any time): index=RESET_ADDR; stack emptied; stack_ovf, stack_unf and wdog_to cleared; watchdog counter cleared. A reset mid-CALL or mid-WAIT discards all sequencing state.
- All state updates on the rising edge of clk. index feeds the ROM combinationally; the next index is a function of the current microword fields. Latency: one cycle per microinstruction.
- Priority: reset > halt > mop. With halt=1 nothing changes, including the watchdog count.
- c = cond_in[cond_sel] XOR cond_inv.
- mop encodings; "inc" means index+1 mod 64, so 63 wraps to 0:
  - 000 JUMP: index <= cr_addr
  - 001 INC: index <= inc
  - 010 DECODE: index <= dec_addr
  - 011 CBR: index <= c ? cr_addr : inc
  - 100 CALL: push inc, then index <= cr_addr.
    - If the stack is full: the jump is still taken, the push is dropped, stack_ovf is set.
  - 101 RET: pop, then index <= popped value.
    - If the stack is empty: index <= RESET_ADDR and stack_unf is set.
  - 110 WAIT: index holds while c=0; when c=1, index <= cr_addr. Typical use is cond_sel=0 (MOC).
  - 111 RESTART: index <= RESET_ADDR and the stack is emptied. Flags are kept.
- Stack is LIFO with depth STACK_DEPTH and a count register 0..STACK_DEPTH. Only one operation per cycle.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MSEQ_WDOG_EN.
- When defined:
  - A counter increments each non-halted cycle spent in WAIT with c=0.
  - It clears on leaving WAIT or on the cycle c=1.
  - When the count reaches WDOG_CYCLES-1 and c is still 0, the next index is TRAP_ADDR, wdog_to is set (sticky), and the counter clears.
- When undefined: no counter is built, WAIT can stall indefinitely, and wdog_to is constant 0.

Decomposition:
- Package mseq_pkg holds:
  - ADDR_W
  - mop encoding constants: MOP_JUMP, MOP_INC, MOP_DECODE, MOP_CBR, MOP_CALL, MOP_RET, MOP_WAIT, MOP_RESTART
  - the cond_in bit-index constants (COND_MOC=0, COND_CT=1)
- One sub-module, mseq_return_stack:
  - inputs: push, pop, data_in, clr
  - outputs: data_out, full, empty
  - same clk and asynchronous reset as the parent.

Test Plan:
- Assert reset mid-sequence with index=9 -> index=0 immediately (asynchronous), flags 0; after release, mop=INC for 3 cycles -> index 1, 2, 3.
- JUMP with cr_addr=63, then INC -> 63, then 0 (wrap); DECODE with dec_addr=12 -> 12.
- CBR, cond_sel=1, cr_addr=20 at index 5:
  - cond_in[1]=1 -> 20.
  - cond_in[1]=1 with cond_inv=1 -> 6.
- WAIT at index 8, cr_addr=9, cond_sel=0: MOC held 0 for 5 cycles -> index stays 8; MOC=1 -> 9 next edge. Also: halt=1 during INC -> index frozen for the halted cycles.
- Stack, STACK_DEPTH=2:
  - CALL 30 from index 4 -> 30; CALL 40 from 31 -> 40; CALL 50 from 41 -> 50 with stack_ovf=1.
  - RET -> 32; RET -> 5; RET -> 0 with stack_unf=1.
- With MSEQ_WDOG_EN, WDOG_CYCLES=16: WAIT with MOC=0 for 16 cycles -> index=63 and wdog_to=1 on the 16th edge. Without the macro, the same stimulus holds the WAIT index and wdog_to stays 0.

Source files
------------

// File: rtl/mseq_pkg.sv
// Shared definitions for the microsequencer: microstore index width,
// next-state op encodings and the named bits of the status vector.
package mseq_pkg;

  // Microstore index width (64-entry microstore).
  localparam int ADDR_W = 6;

  // Width of the status vector and of the op/select fields.
  localparam int COND_W = 8;
  localparam int MOP_W  = 3;
  localparam int CSEL_W = 3;

  // Named status bits inside cond_in.
  localparam int COND_MOC = 0;  // memory operation complete
  localparam int COND_CT  = 1;  // condition-tester result

  // Next-state op carried in every microword.
  typedef enum logic [MOP_W-1:0] {
    MOP_JUMP    = 3'b000,
    MOP_INC     = 3'b001,
    MOP_DECODE  = 3'b010,
    MOP_CBR     = 3'b011,
    MOP_CALL    = 3'b100,
    MOP_RET     = 3'b101,
    MOP_WAIT    = 3'b110,
    MOP_RESTART = 3'b111
  } mop_e;

endpackage

// File: rtl/microsequencer_if.sv
// Microword / status bus between the control store side and the
// microsequencer. The sequencer is the slave: it consumes the next-state
// fields and status bits and returns the registered index and flags.
// There is no valid/ready handshake: every field is sampled on every
// rising clock edge, and halt is the only flow control (halt=1 freezes
// all sequencing state for that cycle).
interface microsequencer_if;
  import mseq_pkg::*;

  logic              halt;
  logic [MOP_W-1:0]  mop;
  logic [ADDR_W-1:0] cr_addr;
  logic [CSEL_W-1:0] cond_sel;
  logic              cond_inv;
  logic [COND_W-1:0] cond_in;
  logic [ADDR_W-1:0] dec_addr;
  logic [ADDR_W-1:0] index;
  logic              stack_ovf;
  logic              stack_unf;
  logic              wdog_to;

  // Control-store side: drives the microword fields and status.
  modport master (
    output halt, mop, cr_addr, cond_sel, cond_inv, cond_in, dec_addr,
    input  index, stack_ovf, stack_unf, wdog_to
  );

  // Sequencer side.
  modport slave (
    input  halt, mop, cr_addr, cond_sel, cond_inv, cond_in, dec_addr,
    output index, stack_ovf, stack_unf, wdog_to
  );

endinterface

// File: rtl/mseq_return_stack.sv
// LIFO return-address stack for microsubroutine CALL/RET.
// Push when full and pop when empty are ignored here; the parent owns the
// overflow/underflow flags. clr empties the stack in one cycle. The caller
// guarantees at most one of push/pop/clr per cycle; clr wins if not.
module mseq_return_stack #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_top_ptr;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_wr_ptr  = PTR_W'(r_count);
  assign w_top_ptr = PTR_W'(r_count - 1'b1);
  assign data_out  = empty ? '0 : r_mem[w_top_ptr];

  // Occupancy count: clear, grow on push, shrink on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage: write the pushed return address into the next free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!clr && push && !full) begin
      r_mem[w_wr_ptr] <= data_in;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: registers the next 6-bit microstore index each cycle from
// the current microword's next-state fields, status bits and the
// instruction encoder dispatch address. Supports jump, increment, decode
// dispatch, conditional branch, call/return through a small return stack,
// wait-for-condition stalls and restart.
// Optional WAIT watchdog: define MSEQ_WDOG_EN to build it; otherwise WAIT
// can stall forever and wdog_to is tied low.
module microsequencer
  import mseq_pkg::*;
#(
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 2,
  parameter int WDOG_CYCLES = 16,
  parameter int TRAP_ADDR   = 63
) (
  input  logic            clk,
  input  logic            reset,
  microsequencer_if.slave bus
);

  logic [ADDR_W-1:0] r_index;
  logic              r_stack_ovf;
  logic              r_stack_unf;

  logic              w_c;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_next;
  logic              w_push;
  logic              w_pop;
  logic              w_clr;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic              w_wdog_hit;
  logic [ADDR_W-1:0] w_stk_out;
  logic              w_stk_full;
  logic              w_stk_empty;

  // Selected, optionally inverted condition; index + 1 wraps 63 -> 0.
  assign w_c   = bus.cond_in[bus.cond_sel] ^ bus.cond_inv;
  assign w_inc = r_index + 1'b1;

  // Next-index and stack-command decode for the current microword.
  always_comb begin
    w_next    = r_index;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clr     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case (bus.mop)
      MOP_JUMP:   w_next = bus.cr_addr;
      MOP_INC:    w_next = w_inc;
      MOP_DECODE: w_next = bus.dec_addr;
      MOP_CBR:    w_next = w_c ? bus.cr_addr : w_inc;
      MOP_CALL: begin
        // The jump is always taken; a full stack only loses the return.
        w_next = bus.cr_addr;
        if (w_stk_full) w_set_ovf = 1'b1;
        else            w_push    = 1'b1;
      end
      MOP_RET: begin
        if (w_stk_empty) begin
          w_next    = ADDR_W'(RESET_ADDR);
          w_set_unf = 1'b1;
        end else begin
          w_next = w_stk_out;
          w_pop  = 1'b1;
        end
      end
      MOP_WAIT: begin
        if (w_c)             w_next = bus.cr_addr;
        else if (w_wdog_hit) w_next = ADDR_W'(TRAP_ADDR);
        else                 w_next = r_index;
      end
      MOP_RESTART: begin
        w_next = ADDR_W'(RESET_ADDR);
        w_clr  = 1'b1;
      end
      default: w_next = r_index;
    endcase
  end

  // Index register: frozen while halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index <= ADDR_W'(RESET_ADDR);
    end else if (!bus.halt) begin
      r_index <= w_next;
    end
  end

  // Sticky stack error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stack_ovf <= 1'b0;
      r_stack_unf <= 1'b0;
    end else if (!bus.halt) begin
      if (w_set_ovf) r_stack_ovf <= 1'b1;
      if (w_set_unf) r_stack_unf <= 1'b1;
    end
  end

  mseq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk      (clk),
    .rst      (reset),
    .push     (w_push && !bus.halt),
    .pop      (w_pop  && !bus.halt),
    .clr      (w_clr  && !bus.halt),
    .data_in  (w_inc),
    .data_out (w_stk_out),
    .full     (w_stk_full),
    .empty    (w_stk_empty)
  );

`ifdef MSEQ_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WD_W-1:0] r_wdog_cnt;
  logic            r_wdog_to;
  logic            w_waiting;

  // Stalled in WAIT this cycle; the last allowed stall cycle trips the trap.
  assign w_waiting  = (bus.mop == MOP_WAIT) && !w_c;
  assign w_wdog_hit = w_waiting && (r_wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  // Stall counter: counts non-halted WAIT stall cycles, clears otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_cnt <= '0;
    end else if (!bus.halt) begin
      if (w_waiting && !w_wdog_hit) r_wdog_cnt <= r_wdog_cnt + 1'b1;
      else                          r_wdog_cnt <= '0;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog_to <= 1'b0;
    end else if (!bus.halt && w_wdog_hit) begin
      r_wdog_to <= 1'b1;
    end
  end

  assign bus.wdog_to = r_wdog_to;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = WDOG_CYCLES[0];
  assign w_wdog_hit    = 1'b0;
  assign bus.wdog_to   = 1'b0;
`endif

  assign bus.index     = r_index;
  assign bus.stack_ovf = r_stack_ovf;
  assign bus.stack_unf = r_stack_unf;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the microsequencer: reset, sequencing ops, branch,
// wait/halt stalls, return stack with overflow/underflow, and the WAIT
// watchdog (expectations follow MSEQ_WDOG_EN).
module tb_microsequencer;
  import mseq_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  microsequencer_if bus ();

  microsequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and watchdog on total run time.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "time limit");
  end

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one microword's next-state fields.
  task automatic drive(input logic [2:0] mop, input logic [ADDR_W-1:0] cr,
                       input logic [2:0] sel, input logic inv,
                       input logic [7:0] cin);
    bus.mop      = mop;
    bus.cr_addr  = cr;
    bus.cond_sel = sel;
    bus.cond_inv = inv;
    bus.cond_in  = cin;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.halt     = 1'b0;
    bus.dec_addr = '0;
    drive(MOP_INC, 6'd0, 3'd0, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_index", 32'(bus.index), 0);

    // Asynchronous reset in the middle of a sequence.
    drive(MOP_JUMP, 6'd9, 3'd0, 1'b0, 8'h00);
    tick();
    check("jump_9", 32'(bus.index), 9);
    reset = 1'b1;
    #2;
    check("async_reset_index", 32'(bus.index), 0);
    check("async_reset_flags", 32'({bus.stack_ovf, bus.stack_unf, bus.wdog_to}), 0);
    reset = 1'b0;
    drive(MOP_INC, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("inc_1", 32'(bus.index), 1);
    tick(); check("inc_2", 32'(bus.index), 2);
    tick(); check("inc_3", 32'(bus.index), 3);

    // Jump to top, wrap on increment, encoder dispatch.
    drive(MOP_JUMP, 6'd63, 3'd0, 1'b0, 8'h00);
    tick(); check("jump_63", 32'(bus.index), 63);
    drive(MOP_INC, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("inc_wrap", 32'(bus.index), 0);
    bus.dec_addr = 6'd12;
    drive(MOP_DECODE, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("decode_12", 32'(bus.index), 12);

    // Conditional branch on the condition-tester bit.
    drive(MOP_JUMP, 6'd5, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CBR, 6'd20, 3'(COND_CT), 1'b0, 8'h02);
    tick(); check("cbr_taken", 32'(bus.index), 20);
    drive(MOP_JUMP, 6'd5, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CBR, 6'd20, 3'(COND_CT), 1'b1, 8'h02);
    tick(); check("cbr_inv_fall", 32'(bus.index), 6);
    drive(MOP_CBR, 6'd20, 3'd7, 1'b0, 8'h80);
    tick(); check("cbr_bit7", 32'(bus.index), 20);

    // WAIT on MOC: hold for 5 cycles, then leave.
    drive(MOP_JUMP, 6'd8, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_WAIT, 6'd9, 3'(COND_MOC), 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(); check("wait_hold", 32'(bus.index), 8);
    end
    bus.cond_in = 8'h01;
    tick(); check("wait_release", 32'(bus.index), 9);

    // Halt freezes an INC.
    drive(MOP_INC, 6'd0, 3'd0, 1'b0, 8'h00);
    bus.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("halt_hold", 32'(bus.index), 9);
    end
    bus.halt = 1'b0;
    tick(); check("halt_release", 32'(bus.index), 10);

    // Return stack: two calls fit, the third overflows.
    drive(MOP_JUMP, 6'd4, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CALL, 6'd30, 3'd0, 1'b0, 8'h00);
    tick(); check("call_30", 32'(bus.index), 30);
    drive(MOP_JUMP, 6'd31, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CALL, 6'd40, 3'd0, 1'b0, 8'h00);
    tick(); check("call_40", 32'(bus.index), 40);
    check("no_ovf_yet", 32'(bus.stack_ovf), 0);
    drive(MOP_JUMP, 6'd41, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CALL, 6'd50, 3'd0, 1'b0, 8'h00);
    tick(); check("call_50", 32'(bus.index), 50);
    check("stack_ovf", 32'(bus.stack_ovf), 1);
    drive(MOP_RET, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("ret_32", 32'(bus.index), 32);
    tick(); check("ret_5", 32'(bus.index), 5);
    check("no_unf_yet", 32'(bus.stack_unf), 0);
    tick(); check("ret_empty", 32'(bus.index), 0);
    check("stack_unf", 32'(bus.stack_unf), 1);
    check("ovf_sticky", 32'(bus.stack_ovf), 1);

    // RESTART empties the stack but keeps the sticky flags.
    drive(MOP_JUMP, 6'd7, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_CALL, 6'd20, 3'd0, 1'b0, 8'h00);
    tick(); check("call_20", 32'(bus.index), 20);
    drive(MOP_RESTART, 6'd33, 3'd0, 1'b0, 8'h00);
    tick(); check("restart_idx", 32'(bus.index), 0);
    check("restart_keeps_flags", 32'({bus.stack_ovf, bus.stack_unf}), 3);
    drive(MOP_RET, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("ret_after_restart", 32'(bus.index), 0);

    // Reset clears the flags; a fresh RET then underflows alone.
    do_reset();
    check("reset_flags_clear", 32'({bus.stack_ovf, bus.stack_unf}), 0);
    drive(MOP_RET, 6'd0, 3'd0, 1'b0, 8'h00);
    tick(); check("unf_only", 32'({bus.stack_ovf, bus.stack_unf}), 1);

    // Watchdog: 16 stalled WAIT cycles.
    do_reset();
    drive(MOP_JUMP, 6'd8, 3'd0, 1'b0, 8'h00);
    tick();
    drive(MOP_WAIT, 6'd9, 3'(COND_MOC), 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) tick();
    check("wdog_15_idx", 32'(bus.index), 8);
    check("wdog_15_flag", 32'(bus.wdog_to), 0);
    tick();
`ifdef MSEQ_WDOG_EN
    check("wdog_16_idx", 32'(bus.index), 63);
    check("wdog_16_flag", 32'(bus.wdog_to), 1);
`else
    check("wdog_16_idx", 32'(bus.index), 8);
    check("wdog_16_flag", 32'(bus.wdog_to), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
